// File: rtl/pixel_readout_buffer.sv
// Purpose: double-buffered pixel row readout; captures full rows and streams them as bus-width beats (optional gray decode via GRAY_DECODE_EN).
// Latency: a row captured at posedge N presents beat 0 during cycle N+1; one beat per cycle thereafter.
// Backpressure: OUT_READY low holds the current beat; ROW_READY drops only when both banks are full.
module pixel_readout_buffer #(
   parameter int PIXEL_ARRAY_WIDTH = 8,
   parameter int OUTPUT_BUS_WIDTH  = 2,
   parameter int PIXEL_BITS        = 8,
   parameter int ROW_IDX_BITS      = 8
) (
   input  logic                                      CLK,
   input  logic                                      RESET_N,
   input  logic                                      ROW_VALID,
   output logic                                      ROW_READY,
   input  logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0]   ROW_DATA,
   output logic                                      OUT_VALID,
   input  logic                                      OUT_READY,
   output logic [OUTPUT_BUS_WIDTH*PIXEL_BITS-1:0]    OUT_DATA,
   output logic                                      OUT_LAST,
   output logic [ROW_IDX_BITS-1:0]                   OUT_ROW_IDX,
   output logic                                      BUSY
);

   localparam int BEATS  = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int ROW_W  = PIXEL_ARRAY_WIDTH * PIXEL_BITS;
   localparam int OUT_W  = OUTPUT_BUS_WIDTH * PIXEL_BITS;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   // Occupancy of the two banks; tracks the number of set full flags.
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_t;

   occ_t                    occ_q;
   occ_t                    occ_d;
   logic [ROW_W-1:0]        bank_a;
   logic [ROW_W-1:0]        bank_b;
   logic [ROW_W-1:0]        row_dec;
   logic [ROW_W-1:0]        rd_bank;
   logic [1:0]              full;
   logic                    wp;
   logic                    rp;
   logic [BEAT_W-1:0]       beat;
   logic [ROW_IDX_BITS-1:0] row_idx;
   logic                    capture;
   logic                    beat_hs;
   logic                    last_hs;

`ifdef GRAY_DECODE_EN
   function automatic logic [PIXEL_BITS-1:0] gray2bin(input logic [PIXEL_BITS-1:0] g);
      logic [PIXEL_BITS-1:0] b;
      b = g;
      for (int i = PIXEL_BITS - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction
`endif

   // Ready depends only on registered state (and reset), never on the drain side this cycle.
   assign ROW_READY = RESET_N & ~full[wp];
   assign capture   = ROW_VALID & ROW_READY;

   assign OUT_VALID   = full[rp];
   assign rd_bank     = rp ? bank_b : bank_a;
   assign OUT_DATA    = OUT_VALID ? rd_bank[int'(beat) * OUT_W +: OUT_W] : '0;
   assign OUT_LAST    = OUT_VALID & (beat == LAST_BEAT);
   assign OUT_ROW_IDX = row_idx;

   assign beat_hs = OUT_VALID & OUT_READY;
   assign last_hs = beat_hs & (beat == LAST_BEAT);

   // Per-pixel decode in front of the bank registers (pass-through when gray decode is off).
   always_comb begin
      row_dec = ROW_DATA;
`ifdef GRAY_DECODE_EN
      for (int p = 0; p < PIXEL_ARRAY_WIDTH; p++) begin
         row_dec[p*PIXEL_BITS +: PIXEL_BITS] = gray2bin(ROW_DATA[p*PIXEL_BITS +: PIXEL_BITS]);
      end
`endif
   end

   // Load the selected bank on capture and advance the write pointer.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         bank_a <= '0;
         bank_b <= '0;
         wp     <= 1'b0;
      end else if (capture) begin
         if (wp) begin
            bank_b <= row_dec;
         end else begin
            bank_a <= row_dec;
         end
         wp <= ~wp;
      end
   end

   // Full flags: set on capture, cleared when the final beat is accepted.
   // Capture needs ~full[wp] and drain needs full[rp], so both never hit the same bank.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         full <= 2'b00;
      end else begin
         if (capture) begin
            full[wp] <= 1'b1;
         end
         if (last_hs) begin
            full[rp] <= 1'b0;
         end
      end
   end

   // Drain position: beat counter, read pointer and row sequence number.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         beat    <= '0;
         rp      <= 1'b0;
         row_idx <= '0;
      end else if (beat_hs) begin
         if (last_hs) begin
            beat    <= '0;
            rp      <= ~rp;
            row_idx <= row_idx + 1'b1;
         end else begin
            beat <= beat + 1'b1;
         end
      end
   end

   // Occupancy state register.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         occ_q <= OCC_EMPTY;
      end else begin
         occ_q <= occ_d;
      end
   end

   // Occupancy next state: capture adds one, final beat removes one, both cancel.
   always_comb begin
      occ_d = occ_q;
      BUSY  = 1'b1;
      case (occ_q)
         OCC_EMPTY: begin
            BUSY = 1'b0;
            if (capture) occ_d = OCC_ONE;
         end
         OCC_ONE: begin
            if (capture && !last_hs)      occ_d = OCC_TWO;
            else if (last_hs && !capture) occ_d = OCC_EMPTY;
         end
         OCC_TWO: begin
            if (last_hs) occ_d = OCC_ONE;
         end
         default: begin
            occ_d = OCC_EMPTY;
            BUSY  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_pixel_readout_buffer.sv
// Bench for pixel_readout_buffer: directed rows, backpressure, back-to-back, gray decode, mid-row reset, then random traffic.
// Expected outputs come from a row-queue model evaluated every cycle, sampled 1 time unit after the falling edge.
// Inputs change only at the falling edge; every wait is bounded.
module tb_pixel_readout_buffer;

   localparam int PAW   = 8;
   localparam int OBW   = 2;
   localparam int PB    = 8;
   localparam int RIB   = 8;
   localparam int BEATS = PAW / OBW;
   localparam int ROW_W = PAW * PB;
   localparam int OUT_W = OBW * PB;

`ifdef GRAY_DECODE_EN
   localparam logic [15:0] FIRST_BEAT_EXP = 16'h1E1F;
   localparam logic [7:0]  GRAY_PX_EXP    = 8'h80;
`else
   localparam logic [15:0] FIRST_BEAT_EXP = 16'h1110;
   localparam logic [7:0]  GRAY_PX_EXP    = 8'hC0;
`endif

   logic             CLK = 1'b0;
   logic             RESET_N = 1'b1;
   logic             ROW_VALID = 1'b0;
   logic             ROW_READY;
   logic [ROW_W-1:0] ROW_DATA = '0;
   logic             OUT_VALID;
   logic             OUT_READY = 1'b0;
   logic [OUT_W-1:0] OUT_DATA;
   logic             OUT_LAST;
   logic [RIB-1:0]   OUT_ROW_IDX;
   logic             BUSY;

   int errors = 0;
   int checks = 0;

   // Reference model: queue of stored rows (already decoded), drain beat, row count.
   logic [ROW_W-1:0] mq[$];
   int               m_beat = 0;
   int               m_idx  = 0;
   int               hs_count = 0;

   pixel_readout_buffer #(
      .PIXEL_ARRAY_WIDTH(PAW),
      .OUTPUT_BUS_WIDTH (OBW),
      .PIXEL_BITS       (PB),
      .ROW_IDX_BITS     (RIB)
   ) dut (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .ROW_VALID  (ROW_VALID),
      .ROW_READY  (ROW_READY),
      .ROW_DATA   (ROW_DATA),
      .OUT_VALID  (OUT_VALID),
      .OUT_READY  (OUT_READY),
      .OUT_DATA   (OUT_DATA),
      .OUT_LAST   (OUT_LAST),
      .OUT_ROW_IDX(OUT_ROW_IDX),
      .BUSY       (BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Gray to binary: binary value is the xor of all right-shifts of the gray code.
   function automatic logic [ROW_W-1:0] model_decode(input logic [ROW_W-1:0] r);
      logic [ROW_W-1:0] o;
      o = r;
`ifdef GRAY_DECODE_EN
      for (int p = 0; p < PAW; p++) begin
         int g;
         int b;
         g = int'(r[p*PB +: PB]);
         b = 0;
         for (int s = g; s != 0; s = s >> 1) b = b ^ s;
         o[p*PB +: PB] = PB'(b);
      end
`endif
      return o;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_beat = 0;
      m_idx  = 0;
   endtask

   task automatic check_reset_zero(input string pfx);
      check({pfx, "_row_ready"}, ROW_READY, 0);
      check({pfx, "_out_valid"}, OUT_VALID, 0);
      check({pfx, "_out_data"},  OUT_DATA, 0);
      check({pfx, "_out_last"},  OUT_LAST, 0);
      check({pfx, "_row_idx"},   OUT_ROW_IDX, 0);
      check({pfx, "_busy"},      BUSY, 0);
   endtask

   task automatic check_outputs();
      logic             ev;
      logic [OUT_W-1:0] ed;
      ev = (mq.size() > 0);
      ed = '0;
      if (ev) ed = mq[0][m_beat*OUT_W +: OUT_W];
      check("row_ready",   ROW_READY, (mq.size() < 2));
      check("out_valid",   OUT_VALID, ev);
      check("out_data",    OUT_DATA, ed);
      check("out_last",    OUT_LAST, ev && (m_beat == BEATS - 1));
      check("out_row_idx", OUT_ROW_IDX, m_idx % (1 << RIB));
      check("busy",        BUSY, ev);
   endtask

   // One clock cycle: drive at the falling edge, check, advance the model at the rising edge.
   task automatic cycle(input logic rv, input logic [ROW_W-1:0] rd, input logic ordy, output logic accepted);
      logic dr;
      ROW_VALID = rv;
      ROW_DATA  = rd;
      OUT_READY = ordy;
      #1;
      check_outputs();
      accepted = rv && (mq.size() < 2);
      dr       = (mq.size() > 0) && ordy;
      if (OUT_VALID && OUT_READY) hs_count++;
      @(posedge CLK);
      if (dr) begin
         if (m_beat == BEATS - 1) begin
            void'(mq.pop_front());
            m_beat = 0;
            m_idx  = (m_idx + 1) % (1 << RIB);
         end else begin
            m_beat++;
         end
      end
      if (accepted) mq.push_back(model_decode(rd));
      @(negedge CLK);
   endtask

   task automatic drain();
      logic acc;
      for (int i = 0; i < 20 && mq.size() > 0; i++) cycle(1'b0, '0, 1'b1, acc);
   endtask

   function automatic logic [ROW_W-1:0] rand_row();
      return {$urandom(), $urandom()};
   endfunction

   initial begin
      logic             acc;
      logic [ROW_W-1:0] row;
      logic [ROW_W-1:0] rows [3];
      int               acc_cyc [3];
      int               k;
      logic             pend_v;
      logic [ROW_W-1:0] pend;

      // Power-on reset.
      #2 RESET_N = 1'b0;
      #1 check_reset_zero("por");
      @(negedge CLK);
      @(negedge CLK);
      RESET_N = 1'b1;
      model_reset();
      cycle(1'b0, '0, 1'b1, acc);

      // Single row 0x10..0x17, with 3 cycles of backpressure on beat 1.
      row = 64'h1716151413121110;
      cycle(1'b1, row, 1'b1, acc);
      check("single_acc", acc, 1);
      check("single_beat0", OUT_DATA, FIRST_BEAT_EXP);
      cycle(1'b0, '0, 1'b1, acc);
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, acc);
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, acc);

      // Three rows offered back to back with the output always ready.
      for (int i = 0; i < 3; i++) rows[i] = rand_row();
      k = 0;
      hs_count = 0;
      for (int i = 0; i < 30 && !(k == 3 && mq.size() == 0); i++) begin
         cycle(k < 3, (k < 3) ? rows[k % 3] : '0, 1'b1, acc);
         if (acc) begin
            acc_cyc[k] = i;
            k++;
         end
      end
      check("b2b_rows", k, 3);
      check("b2b_beats", hs_count, 12);
      check("b2b_row1_gap", acc_cyc[1] - acc_cyc[0], 1);
      check("b2b_row2_gap", acc_cyc[2] - acc_cyc[0], 5);

      // Gray decode of pixel 0 = 0xC0.
      row = rand_row();
      row[7:0] = 8'hC0;
      cycle(1'b1, row, 1'b1, acc);
      check("gray_px0", OUT_DATA[7:0], GRAY_PX_EXP);
      drain();

      // Reset in the middle of row 0 with row 1 queued.
      cycle(1'b1, rand_row(), 1'b1, acc);
      cycle(1'b1, rand_row(), 1'b1, acc);
      cycle(1'b0, '0, 1'b1, acc);
      cycle(1'b0, '0, 1'b1, acc);
      #3 RESET_N = 1'b0;
      #1 check_reset_zero("mid");
      model_reset();
      @(negedge CLK);
      RESET_N = 1'b1;
      #1;
      check("mid_rel_ready", ROW_READY, 1);
      check("mid_rel_busy", BUSY, 0);
      check("mid_rel_idx", OUT_ROW_IDX, 0);
      @(negedge CLK);
      cycle(1'b1, rand_row(), 1'b1, acc);
      drain();

      // Random traffic; upstream holds an offered row until it is taken.
      pend_v = 1'b0;
      pend   = rand_row();
      for (int i = 0; i < 2500; i++) begin
         if (!pend_v) pend_v = ($urandom_range(0, 3) != 0);
         cycle(pend_v, pend_v ? pend : rand_row(), ($urandom_range(0, 3) != 0), acc);
         if (acc) begin
            pend_v = 1'b0;
            pend   = rand_row();
         end
      end
      drain();
      cycle(1'b0, '0, 1'b1, acc);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/pixel_readout_buffer.md
# pixel_readout_buffer

Double-buffered, parametrised readout stage between the pixel array and the chip output bus. It accepts one full pixel row per valid/ready handshake and streams it out as `PIXEL_ARRAY_WIDTH/OUTPUT_BUS_WIDTH` beats on a valid/ready output port, with backpressure. A second row can be captured while the first is still draining. It supersedes the fixed-rate, single-bank output buffer. Gray-to-binary decoding is optional and selected at compile time.

## Interface

Parameters:
- `PIXEL_ARRAY_WIDTH`, default 8: pixels per row; must be an integer multiple of `OUTPUT_BUS_WIDTH`.
- `OUTPUT_BUS_WIDTH`, default 2: pixels per output beat.
- `PIXEL_BITS`, default 8: bits per pixel.
- `ROW_IDX_BITS`, default 8: width of the row sequence counter.
- Derived: `BEATS = PIXEL_ARRAY_WIDTH/OUTPUT_BUS_WIDTH`; beat counter width `max(1,$clog2(BEATS))`.

Ports:
- `CLK` in 1: single clock; all state updates on posedge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `ROW_VALID` in 1: `ROW_DATA` holds a complete row.
- `ROW_READY` out 1: buffer can accept a row this cycle.
- `ROW_DATA` in `PIXEL_ARRAY_WIDTH*PIXEL_BITS`: row; pixel i occupies bits `[i*PIXEL_BITS +: PIXEL_BITS]`.
- `OUT_VALID` out 1: `OUT_DATA` holds a valid beat.
- `OUT_READY` in 1: downstream accepts the beat.
- `OUT_DATA` out `OUTPUT_BUS_WIDTH*PIXEL_BITS`: current beat.
- `OUT_LAST` out 1: current beat is the final beat of its row.
- `OUT_ROW_IDX` out `ROW_IDX_BITS`: sequence number of the row being output.
- `BUSY` out 1: at least one bank is full.

## Operation

- Storage: two banks, A and B, each `PIXEL_ARRAY_WIDTH*PIXEL_BITS` bits, each with a `full` flag.
  - Write pointer `wp` selects the bank to fill.
  - Read pointer `rp` selects the bank to drain.
  - Beat counter `beat` tracks the drain position.
- Occupancy FSM, derived from the full flags:
  - EMPTY (0 full), ONE (1 full), TWO (2 full).
  - Transitions: capture only +1; final beat accepted only −1; both in the same cycle keep the state.
- Capture:
  - A capture occurs when `ROW_VALID & ROW_READY` at posedge.
  - Bank[wp] is loaded with the row (decoded per Configuration), `full[wp]` is set, and `wp` toggles.
  - `ROW_READY = RESET_N & ~full[wp]`. It is a function of registers only; there is no same-cycle pass-through from drain to ready.
- Drain:
  - `OUT_VALID = full[rp]`.
  - `OUT_DATA` = pixels `[beat*OUTPUT_BUS_WIDTH +: OUTPUT_BUS_WIDTH]` of bank[rp], lowest pixel in the lowest bits. It is 0 when `OUT_VALID` is low.
  - `OUT_LAST = OUT_VALID & (beat == BEATS-1)`.
- On `OUT_VALID & OUT_READY`:
  - If not the last beat: `beat` increments.
  - If the last beat: `beat` returns to 0, `full[rp]` clears, `rp` toggles, and `OUT_ROW_IDX` increments, wrapping modulo `2^ROW_IDX_BITS`.
- `BUSY = full[A] | full[B]`.

## Timing

- Reset (`RESET_N` low, asynchronous): all outputs are 0. This includes `ROW_READY`, `OUT_VALID`, `OUT_DATA`, `OUT_LAST`, `OUT_ROW_IDX` and `BUSY`. Internally, `wp`, `rp`, `beat`, full flags and bank contents are all 0.
- Reset release: `ROW_READY` rises combinationally with `RESET_N`. The first capture is possible at the first posedge after release.
- Latency: a row captured at posedge N gives `OUT_VALID` high during cycle N+1, with beat 0 presented.
- Throughput: with `OUT_READY` held at 1 and rows always available, `OUT_VALID` stays continuously high (one beat per cycle) with no bubble between rows.
- Backpressure: while `OUT_VALID & ~OUT_READY`, `OUT_DATA`, `OUT_LAST` and `OUT_ROW_IDX` hold stable.
- Full condition (TWO): `ROW_READY` is low. It rises in the cycle after the final beat of bank[rp] is accepted.
- Simultaneous capture and final beat, when they target different banks: both take effect in the same cycle.
- `ROW_VALID` without `ROW_READY`: no state change. The upstream holds its data.
- Reset mid-row: in-flight beats and any captured rows are discarded with no partial completion.

## Configuration

- `GRAY_DECODE_EN` defined:
  - Each pixel is converted gray→binary on capture: `b[MSB]=g[MSB]`, `b[i]=b[i+1]^g[i]`.
  - The conversion is combinational ahead of the bank registers; latency is unchanged.
- `GRAY_DECODE_EN` undefined: pixels are stored and output unchanged.

## Test plan

- Reset: assert `RESET_N`=0 mid-simulation → all outputs 0 immediately. Release → `ROW_READY`=1; `OUT_VALID`=0 until the first capture.
- Single row, defaults, `OUT_READY`=1:
  - Stimulus: pixels 0..7 = 0x10..0x17, captured at posedge N.
  - Required response: beats at cycles N+1..N+4 are `{0x11,0x10}`, `{0x13,0x12}`, `{0x15,0x14}`, `{0x17,0x16}`.
  - `OUT_LAST` only on the 4th beat; `OUT_ROW_IDX`=0; `BUSY` falls after the 4th beat.
- Backpressure: hold `OUT_READY`=0 for 3 cycles while beat 1 is presented → `OUT_DATA`={0x13,0x12} stable throughout; stream resumes with beat 2.
- Back-to-back rows:
  - Stimulus: offer 3 rows continuously, `OUT_READY`=1.
  - Rows 0 and 1 are accepted on consecutive edges.
  - Row 2's `ROW_READY` stays low until the cycle after row 0's `OUT_LAST` handshake.
  - 12 beats are emitted with `OUT_ROW_IDX` 0,0,0,0,1,…,2.
- Gray decode: pixel 0xC0 → `OUT_DATA` pixel 0x80 with `GRAY_DECODE_EN`; 0xC0 without it.
- Reset mid-operation: assert reset after beat 2 of row 0 with row 1 queued → after release, `BUSY`=0 and `OUT_ROW_IDX`=0. The next captured row outputs from beat 0.
